// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM master port between the VGA read client (priority) and the frame-upload
// write client; it counts outstanding reads so that no read data is lost when ownership changes.
//
// state       | meaning
// ST_IDLE     | no owner; address and write data held at 0
// ST_RD_OWN   | read client owns the port
// ST_RD_DRAIN | read session ended; waiting for outstanding read data
// ST_WR_OWN   | write client owns the port
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8,
  localparam int CW         = $clog2(MAX_PENDING + 1)
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iRD_REQ,
  output logic              oRD_GNT,
  input  logic              iRD_EN,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_WAIT_REQUEST,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_DATAVALID,
  input  logic              iWR_REQ,
  output logic              oWR_GNT,
  input  logic              iWR_EN,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  output logic              oWR_WAIT_REQUEST,
  output logic [ADDR_W-1:0] oSD_ADDR,
  output logic              oSD_READ,
  output logic              oSD_WRITE,
  output logic [DATA_W-1:0] oSD_WRITEDATA,
  input  logic              iSD_WAITREQUEST,
  input  logic [DATA_W-1:0] iSD_READDATA,
  input  logic              iSD_READDATAVALID,
  output logic [CW-1:0]     oPENDING,
  output logic              oERR
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_OWN   = 2'd1,
    ST_RD_DRAIN = 2'd2,
    ST_WR_OWN   = 2'd3
  } state_t;

  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] pending;
  logic          err;
  logic          rdAccept;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= ST_IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (iRD_REQ)      stateNext = ST_RD_OWN;
        else if (iWR_REQ) stateNext = ST_WR_OWN;
      end
      ST_RD_OWN: begin
        if (!iRD_REQ) stateNext = ST_RD_DRAIN;
      end
      ST_RD_DRAIN: begin
        if (pending == '0) stateNext = ST_IDLE;
      end
      ST_WR_OWN: begin
        // a stalled write must complete before the reader may take over
        if (!iWR_REQ)                                      stateNext = ST_IDLE;
        else if (iRD_REQ && !(iWR_EN && iSD_WAITREQUEST)) stateNext = ST_RD_OWN;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign oRD_GNT = (state == ST_RD_OWN);
  assign oWR_GNT = (state == ST_WR_OWN);

  always_comb begin
    oSD_READ         = 1'b0;
    oSD_WRITE        = 1'b0;
    oSD_ADDR         = '0;
    oSD_WRITEDATA    = '0;
    oRD_WAIT_REQUEST = 1'b1;
    oWR_WAIT_REQUEST = 1'b1;
    case (state)
      ST_RD_OWN: begin
        oSD_READ         = iRD_EN && (pending < PEND_MAX);
        oSD_ADDR         = iRD_ADDR;
        oRD_WAIT_REQUEST = iSD_WAITREQUEST || (pending == PEND_MAX);
      end
      ST_WR_OWN: begin
        oSD_WRITE        = iWR_EN;
        oSD_ADDR         = iWR_ADDR;
        oSD_WRITEDATA    = iWR_DATA;
        oWR_WAIT_REQUEST = iSD_WAITREQUEST;
      end
      default: ;
    endcase
  end

  assign rdAccept = oSD_READ && !iSD_WAITREQUEST;

  // data with nothing outstanding is flagged but never drives the count below zero
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (iSD_READDATAVALID && (pending == '0)) err <= 1'b1;
      if (rdAccept && !iSD_READDATAVALID)
        pending <= pending + CW'(1);
      else if (!rdAccept && iSD_READDATAVALID && (pending != '0))
        pending <= pending - CW'(1);
    end
  end

  assign oPENDING      = pending;
  assign oERR          = err;
  assign oRD_DATA      = iSD_READDATA;
  assign oRD_DATAVALID = iSD_READDATAVALID;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed session scenarios plus a randomized phase,
// checked against a queue-based model of outstanding reads and accepted writes.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;
  localparam int MP = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rstN;
  logic          rdReq, rdEn, wrReq, wrEn;
  logic [AW-1:0] rdAddr, wrAddr;
  logic [DW-1:0] wrData;
  logic          sdWait, sdRvalid;
  logic [DW-1:0] sdRdata;

  logic          oRD_GNT, oRD_WAIT_REQUEST, oRD_DATAVALID;
  logic [DW-1:0] oRD_DATA;
  logic          oWR_GNT, oWR_WAIT_REQUEST;
  logic [AW-1:0] oSD_ADDR;
  logic          oSD_READ, oSD_WRITE;
  logic [DW-1:0] oSD_WRITEDATA;
  logic [CW-1:0] oPENDING;
  logic          oERR;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
    .iCLK(clk), .iRST_N(rstN),
    .iRD_REQ(rdReq), .oRD_GNT(oRD_GNT), .iRD_EN(rdEn), .iRD_ADDR(rdAddr),
    .oRD_WAIT_REQUEST(oRD_WAIT_REQUEST), .oRD_DATA(oRD_DATA), .oRD_DATAVALID(oRD_DATAVALID),
    .iWR_REQ(wrReq), .oWR_GNT(oWR_GNT), .iWR_EN(wrEn), .iWR_ADDR(wrAddr), .iWR_DATA(wrData),
    .oWR_WAIT_REQUEST(oWR_WAIT_REQUEST),
    .oSD_ADDR(oSD_ADDR), .oSD_READ(oSD_READ), .oSD_WRITE(oSD_WRITE), .oSD_WRITEDATA(oSD_WRITEDATA),
    .iSD_WAITREQUEST(sdWait), .iSD_READDATA(sdRdata), .iSD_READDATAVALID(sdRvalid),
    .oPENDING(oPENDING), .oERR(oERR)
  );

  typedef struct {logic [AW-1:0] addr; int due;} rdTxn_t;

  int            nCmp = 0;
  int            nMis = 0;
  int            cyc = 0;
  int            waitMode = 0;   // 0 none, 1 every 7th cycle, 2 random, 3 forced
  int            retBudget = -1; // <0 unlimited read returns, otherwise returns still allowed
  int            ctrlAccepts = 0;
  int            rdIssued = 0;
  int            wrIssued = 0;
  int            rdValids = 0;
  int            refPend = 0;
  bit            refErr = 0;
  int            maxPend = 0;
  rdTxn_t        ctrlQ[$];
  logic [DW-1:0] expRd[$];
  logic [AW+DW-1:0] expWr[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] memFn(input logic [AW-1:0] a);
    return a[15:0] ^ {7'h35, a[24:16]};
  endfunction

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SDRAM controller model: fixed read latency of 3, stall pattern selected by waitMode
  initial begin
    sdWait = 0; sdRvalid = 0; sdRdata = '0;
    forever begin
      @(negedge clk);
      if (oSD_READ && !sdWait) begin
        ctrlQ.push_back('{oSD_ADDR, cyc + 3});
        ctrlAccepts++;
      end
      @(posedge clk);
      #2;
      cyc++;
      sdRvalid = 0;
      sdRdata  = DW'($urandom);
      if (ctrlQ.size() > 0 && ctrlQ[0].due <= cyc && retBudget != 0) begin
        sdRvalid = 1;
        sdRdata  = memFn(ctrlQ[0].addr);
        void'(ctrlQ.pop_front());
        if (retBudget > 0) retBudget--;
      end
      case (waitMode)
        1:       sdWait = (cyc % 7 == 0);
        2:       sdWait = ($urandom_range(0, 3) == 0);
        3:       sdWait = 1;
        default: sdWait = 0;
      endcase
    end
  end

  // stimulus side: every transfer the clients see accepted pushes its expected result
  initial begin
    forever begin
      @(negedge clk);
      if (rstN && rdEn && !oRD_WAIT_REQUEST) begin
        expRd.push_back(memFn(rdAddr));
        rdIssued++;
      end
      if (rstN && wrEn && !oWR_WAIT_REQUEST) begin
        expWr.push_back({wrAddr, wrData});
        wrIssued++;
      end
    end
  end

  // monitor: compares DUT outputs against the queues and the outstanding-read model
  initial begin
    logic [AW+DW-1:0] w;
    logic [DW-1:0]    d;
    bit               rdAcc;
    forever begin
      @(negedge clk);
      checkEq("data_passthru", {oRD_DATAVALID, oRD_DATA}, {sdRvalid, sdRdata});
      if (!rstN) begin
        checkEq("reset_outputs",
                {oRD_GNT, oWR_GNT, oSD_READ, oSD_WRITE, oRD_WAIT_REQUEST, oWR_WAIT_REQUEST, oPENDING, oERR, oSD_ADDR, oSD_WRITEDATA},
                {6'b000011, 4'd0, 1'b0, 25'd0, 16'd0});
        refPend = 0;
        refErr  = 0;
        continue;
      end
      if (int'(oPENDING) > maxPend) maxPend = int'(oPENDING);
      checkEq("pending", oPENDING, refPend);
      checkEq("err", oERR, refErr);
      checkEq("gnt_exclusive", oRD_GNT && oWR_GNT, 0);
      checkEq("strobe_exclusive", oSD_READ && oSD_WRITE, 0);
      if (oRD_GNT) begin
        checkEq("rd_fwd", {oSD_READ, oRD_WAIT_REQUEST, oSD_ADDR},
                {rdEn && (refPend < MP), sdWait || (refPend == MP), rdAddr});
        checkEq("rd_owner_wr_side", {oWR_WAIT_REQUEST, oSD_WRITE}, 2'b10);
      end else if (oWR_GNT) begin
        checkEq("wr_fwd", {oSD_WRITE, oWR_WAIT_REQUEST, oSD_ADDR, oSD_WRITEDATA},
                {wrEn, sdWait, wrAddr, wrData});
        checkEq("wr_owner_rd_side", {oRD_WAIT_REQUEST, oSD_READ}, 2'b10);
        checkEq("wr_own_pending", oPENDING, 0);
      end else begin
        checkEq("no_owner_outputs",
                {oSD_READ, oSD_WRITE, oRD_WAIT_REQUEST, oWR_WAIT_REQUEST, oSD_ADDR, oSD_WRITEDATA},
                {4'b0011, 25'd0, 16'd0});
      end
      if (oSD_WRITE && !sdWait) begin
        if (expWr.size() == 0) checkEq("wr_unexpected", 1, 0);
        else begin
          w = expWr.pop_front();
          checkEq("wr_xfer", {oSD_ADDR, oSD_WRITEDATA}, w);
        end
      end
      if (oRD_DATAVALID) begin
        rdValids++;
        if (expRd.size() == 0) checkEq("rd_unexpected", 1, 0);
        else begin
          d = expRd.pop_front();
          checkEq("rd_data", oRD_DATA, d);
        end
      end
      rdAcc = rdEn && !oRD_WAIT_REQUEST;
      if (sdRvalid && refPend == 0) refErr = 1;
      if (rdAcc && !sdRvalid) refPend++;
      else if (!rdAcc && sdRvalid && refPend > 0) refPend--;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched so far", nCmp, nMis);
    $fatal(1, "watchdog");
  end

  task automatic waitGnt(input bit rd);
    int n = 0;
    while ((rd ? !oRD_GNT : !oWR_GNT) && n < 50) begin tick(); n++; end
    checkEq(rd ? "rd_gnt_timeout" : "wr_gnt_timeout", rd ? oRD_GNT : oWR_GNT, 1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((oRD_GNT || oWR_GNT || oPENDING != 0 || ctrlQ.size() != 0) && n < 200) begin tick(); n++; end
    checkEq("idle_timeout", n < 200, 1);
    repeat (2) tick();
  endtask

  task automatic issueReads(input int cnt);
    int i0 = rdIssued;
    int n = 0;
    rdEn = 1;
    while (rdIssued - i0 < cnt && n < 50) begin rdAddr = AW'($urandom); tick(); n++; end
    rdEn = 0;
    checkEq("issue_reads", rdIssued - i0, cnt);
  endtask

  initial begin
    int i0, a0, v0, n;
    rstN = 0; rdReq = 0; rdEn = 0; wrReq = 0; wrEn = 0;
    rdAddr = '0; wrAddr = '0; wrData = '0;
    repeat (3) tick();
    rstN = 1;
    tick();

    // simultaneous request: read wins
    rdReq = 1; wrReq = 1;
    tick();
    checkEq("t1_rd_gnt", oRD_GNT, 1);
    checkEq("t1_wr_gnt", oWR_GNT, 0);
    checkEq("t1_wr_wait", oWR_WAIT_REQUEST, 1);
    rdReq = 0; wrReq = 0;
    waitIdle();

    // 512-word line fetch with periodic controller stalls
    waitMode = 1; maxPend = 0;
    a0 = ctrlAccepts; v0 = rdValids; i0 = rdIssued; n = 0;
    rdReq = 1;
    waitGnt(1);
    rdEn = 1;
    while (rdIssued - i0 < 512 && n < 3000) begin
      rdAddr = AW'(32'h1000 + rdIssued - i0);
      tick(); n++;
    end
    rdEn = 0; rdReq = 0;
    tick();
    tick();
    checkEq("t2_drain_gnt", oRD_GNT, 0);
    waitIdle();
    checkEq("t2_accepts", ctrlAccepts - a0, 512);
    checkEq("t2_valids", rdValids - v0, 512);
    checkEq("t2_max_pending_le3", maxPend <= 3, 1);
    waitMode = 0;

    // pending limit with no returned data
    retBudget = 0; i0 = rdIssued;
    rdReq = 1;
    waitGnt(1);
    rdEn = 1;
    repeat (12) begin rdAddr = AW'($urandom); tick(); end
    checkEq("t3_accepts", rdIssued - i0, MP);
    checkEq("t3_read_blocked", oSD_READ, 0);
    checkEq("t3_wait", oRD_WAIT_REQUEST, 1);
    checkEq("t3_pending_full", oPENDING, MP);
    retBudget = 1;
    repeat (5) tick();
    checkEq("t3_one_more", rdIssued - i0, MP + 1);
    checkEq("t3_pending_refull", oPENDING, MP);
    retBudget = -1; rdEn = 0; rdReq = 0;
    waitIdle();

    // write preemption waits for a stalled write
    wrReq = 1;
    waitGnt(0);
    wrEn = 1; wrAddr = AW'($urandom); wrData = DW'($urandom);
    i0 = wrIssued;
    tick();
    waitMode = 3; rdReq = 1;
    wrAddr = AW'($urandom); wrData = DW'($urandom);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checkEq("t4_wr_held", {oWR_GNT, oRD_GNT}, 2'b10);
    end
    waitMode = 0;
    tick();
    checkEq("t4_rd_takeover", {oWR_GNT, oRD_GNT}, 2'b01);
    checkEq("t4_writes_done", wrIssued - i0, 2);
    checkEq("t4_no_write_lost", expWr.size(), 0);
    wrEn = 0; wrReq = 0; rdReq = 0;
    waitIdle();

    // drain blocks the writer until outstanding reads return
    retBudget = 0;
    rdReq = 1;
    waitGnt(1);
    issueReads(2);
    rdReq = 0; wrReq = 1;
    repeat (4) begin
      tick();
      checkEq("t5_wr_blocked", oWR_GNT, 0);
    end
    checkEq("t5_pending2", oPENDING, 2);
    retBudget = -1;
    n = 0;
    while (oPENDING != 0 && n < 20) begin
      checkEq("t5_wr_blocked_drain", oWR_GNT, 0);
      tick(); n++;
    end
    checkEq("t5_drained", oPENDING, 0);
    checkEq("t5_gnt_at_zero", oWR_GNT, 0);
    tick();
    checkEq("t5_gnt_idle", oWR_GNT, 0);
    tick();
    checkEq("t5_gnt_rise", oWR_GNT, 1);
    wrReq = 0;
    waitIdle();

    // reset with reads outstanding, then late data
    retBudget = 0;
    rdReq = 1;
    waitGnt(1);
    issueReads(5);
    rdReq = 0;
    checkEq("t6_pending5", oPENDING, 5);
    rstN = 0;
    #1;
    checkEq("t6_reset_now", {oRD_GNT, oWR_GNT, oPENDING, oERR, oRD_WAIT_REQUEST, oWR_WAIT_REQUEST}, 10'b0000000011);
    repeat (2) tick();
    rstN = 1;
    tick();
    v0 = rdValids;
    retBudget = -1;
    n = 0;
    while (rdValids == v0 && n < 20) begin tick(); n++; end
    checkEq("t6_err_set", oERR, 1);
    checkEq("t6_pending0", oPENDING, 0);
    repeat (8) tick();
    checkEq("t6_all_late", rdValids - v0, 5);
    checkEq("t6_pending_stays0", oPENDING, 0);
    rstN = 0;
    repeat (2) tick();
    rstN = 1;
    tick();

    // randomized sessions with random stalls
    waitMode = 2;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) rdReq = !rdReq;
      if ($urandom_range(0, 14) == 0) wrReq = !wrReq;
      rdEn   = rdReq && ($urandom_range(0, 2) != 0);
      wrEn   = wrReq && ($urandom_range(0, 1) != 0);
      rdAddr = AW'($urandom);
      wrAddr = AW'($urandom);
      wrData = DW'($urandom);
      tick();
    end
    rdReq = 0; wrReq = 0; rdEn = 0; wrEn = 0;
    waitIdle();
    checkEq("rand_reads_returned", expRd.size(), 0);
    checkEq("rand_writes_done", expWr.size(), 0);
    checkEq("rand_err_clear", oERR, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
